// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ----------------
// Round-robin arbiter that shares one UART transmitter among N_REQ byte
// producers. One pending requester is picked at a time. Its byte goes to the
// transmitter with a one-cycle strobe. The next grant waits until the
// transmitter has taken that byte (uart_rfd falls) or until a watchdog gives
// up on it.
//
// Handshake (one place, all channels):
//   requester side : req_vld[i] is held high with stable req_data slice i
//                    until req_ack[i] pulses for one cycle. Dropping req_vld[i]
//                    before the ack withdraws the byte.
//   transmitter    : uart_din_vld is a one-cycle strobe that carries uart_din.
//                    A grant is only made while uart_rfd=1 (transmitter idle).
//                    uart_rfd falling afterwards is the acceptance.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   req_vld       per-requester "byte pending"
//   req_data      byte of requester i in [i*DI_WIDTH +: DI_WIDTH]
//   req_ack       one-cycle pulse on the granted requester's bit
//   uart_din      byte to the transmitter (held until the next grant)
//   uart_din_vld  one-cycle strobe to the transmitter
//   uart_rfd      transmitter ready for data (high = idle)
//   grant_id      index of the last granted requester
//   busy          high while a byte is being sent or awaited (SEND/BUSY)
//   timeout_err   one-cycle pulse when the watchdog abandons a byte
//   dbg_state     current FSM state (0 idle, 1 send, 2 busy)

module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DI_WIDTH = 8,
  parameter int TIMEOUT  = 16,
  localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_vld,
  input  logic [N_REQ*DI_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]          req_ack,
  output logic [DI_WIDTH-1:0]       uart_din,
  output logic                      uart_din_vld,
  input  logic                      uart_rfd,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [1:0]                dbg_state
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         ptr, ptr_nxt;
  logic [WW-1:0]         wdog, wdog_nxt;
  logic [N_REQ-1:0]      ack_nxt;
  logic [DI_WIDTH-1:0]   din_nxt;
  logic                  din_vld_nxt;
  logic [GW-1:0]         gid_nxt;
  logic                  terr_nxt;

  logic                  req_any;
  logic [GW-1:0]         win_id;
  logic [GW-1:0]         idx;
  logic                  grant;
  logic                  wdog_expired;

  // Rotating priority search starting at ptr. The loop runs from the farthest
  // offset down to offset 0, so the nearest pending requester writes last and wins.
  always_comb begin
    req_any = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = GW'((int'(ptr) + k) % N_REQ);
      if (req_vld[idx]) begin
        req_any = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign grant = (state == ST_IDLE) && uart_rfd && req_any;

  // The counter starts at 0 in the first BUSY cycle. The byte is abandoned on
  // the BUSY cycle that would have advanced it to TIMEOUT-1. That gives
  // TIMEOUT-1 BUSY cycles with rfd high, so timeout_err lands exactly TIMEOUT
  // cycles after the SEND cycle.
  assign wdog_expired = (wdog == WW'(TIMEOUT - 2));

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      wdog         <= '0;
      req_ack      <= '0;
      uart_din     <= '0;
      uart_din_vld <= 1'b0;
      grant_id     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      wdog         <= wdog_nxt;
      req_ack      <= ack_nxt;
      uart_din     <= din_nxt;
      uart_din_vld <= din_vld_nxt;
      grant_id     <= gid_nxt;
      timeout_err  <= terr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_SEND;
      ST_SEND: state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (!uart_rfd || wdog_expired) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ack_nxt     = '0;
    din_vld_nxt = 1'b0;
    terr_nxt    = 1'b0;
    din_nxt     = uart_din;
    gid_nxt     = grant_id;
    ptr_nxt     = ptr;
    wdog_nxt    = wdog;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          din_nxt         = req_data[int'(win_id)*DI_WIDTH +: DI_WIDTH];
          gid_nxt         = win_id;
          ack_nxt[win_id] = 1'b1;
          din_vld_nxt     = 1'b1;
          ptr_nxt         = (int'(win_id) == N_REQ - 1) ? '0 : win_id + GW'(1);
        end
      end
      ST_SEND: begin
        wdog_nxt = '0;
      end
      ST_BUSY: begin
        if (uart_rfd) begin
          if (wdog_expired) terr_nxt = 1'b1;
          else              wdog_nxt = wdog + WW'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// ------------------
// Self-checking bench for uart_tx_arbiter (N_REQ=4, DI_WIDTH=8, TIMEOUT=16).
// A behavioural model tracks "arbiter idle / cycles since the last grant" and
// a rotating priority pointer. From these it predicts every output on every
// cycle. Directed scenarios add literal expectations for grant order, latency,
// watchdog timing and reset. A long randomized phase follows.

module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [W-1:0]   uart_din;
  logic           uart_din_vld;
  logic           uart_rfd;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;
  logic [1:0]     dbg_state;

  uart_tx_arbiter #(.N_REQ(N), .DI_WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .uart_din     (uart_din),
    .uart_din_vld (uart_din_vld),
    .uart_rfd     (uart_rfd),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- behavioural model ----------------
  // m_active: a byte has been granted and is not yet resolved.
  // m_age   : cycles elapsed since the grant's strobe cycle (0 = strobe cycle).
  int           m_ptr;
  bit           m_active;
  int           m_age;
  logic [N-1:0] e_ack;
  logic         e_vld, e_terr, e_busy;
  logic [W-1:0] e_din;
  logic [1:0]   e_gid;
  int           grants[$];

  int n_w;
  bit n_grant, n_act, n_terr;
  int n_age;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always_comb begin
    n_w     = pick(req_vld, m_ptr);
    n_grant = 1'b0;
    n_act   = m_active;
    n_age   = m_age;
    n_terr  = 1'b0;
    if (!m_active) begin
      if (uart_rfd && n_w >= 0) begin
        n_grant = 1'b1;
        n_act   = 1'b1;
        n_age   = 0;
      end
    end else if (m_age == 0) begin
      n_age = 1;
    end else if (!uart_rfd) begin
      n_act = 1'b0;
    end else if (m_age == TMO - 1) begin
      n_act  = 1'b0;
      n_terr = 1'b1;
    end else begin
      n_age = m_age + 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr    <= 0;
      m_active <= 1'b0;
      m_age    <= 0;
      e_ack    <= '0;
      e_vld    <= 1'b0;
      e_terr   <= 1'b0;
      e_busy   <= 1'b0;
      e_din    <= '0;
      e_gid    <= '0;
    end else begin
      m_active <= n_act;
      m_age    <= n_age;
      e_busy   <= n_act;
      e_terr   <= n_terr;
      e_vld    <= n_grant;
      e_ack    <= n_grant ? (4'b0001 << n_w) : 4'b0000;
      if (n_grant) begin
        e_din <= W'(req_data >> (n_w * W));
        e_gid <= 2'(n_w);
        m_ptr <= (n_w + 1) % N;
        grants.push_back(n_w);
      end
    end
  end

  // ---------------- scoreboard / checks ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  bit auto_drop, hold_all, rand_req, tx_auto, tx_rand;
  int tx_len, tx_left;
  int ack_cycles;

  task automatic set_req(input int i, input logic [W-1:0] d);
    req_vld[i]         = 1'b1;
    req_data[i*W +: W] = d;
  endtask

  // One cycle: wait for the falling edge, compare every output against the
  // model, then let the requester / transmitter behaviours react.
  task automatic step();
    @(negedge clk);
    chk("cyc_ack",  req_ack,      e_ack);
    chk("cyc_vld",  uart_din_vld, e_vld);
    chk("cyc_din",  uart_din,     e_din);
    chk("cyc_gid",  grant_id,     e_gid);
    chk("cyc_busy", busy,         e_busy);
    chk("cyc_terr", timeout_err,  e_terr);
    chk("cyc_dbg",  dbg_state == 2'd0, !e_busy);
    if (req_ack != '0) ack_cycles++;

    if (tx_auto) begin
      if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) uart_rfd = 1'b1;
      end else if (uart_din_vld) begin
        if (tx_rand && $urandom_range(0, 9) == 0) begin
          tx_left = 0;  // transmitter never answers: watchdog path
        end else begin
          uart_rfd = 1'b0;
          tx_left  = tx_rand ? int'($urandom_range(1, 8)) : tx_len;
        end
      end
    end

    for (int i = 0; i < N; i++) begin
      if (req_vld[i] && req_ack[i]) begin
        if (hold_all) req_data[i*W +: W] = W'($urandom);
        else if (auto_drop) req_vld[i] = 1'b0;
        else if (rand_req) begin
          req_vld[i]         = ($urandom_range(0, 1) == 0);
          req_data[i*W +: W] = W'($urandom);
        end
      end else if (rand_req) begin
        if (!req_vld[i]) begin
          if ($urandom_range(0, 7) == 0) set_req(i, W'($urandom));
        end else if ($urandom_range(0, 63) == 0) begin
          req_vld[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"},  req_ack,      0);
    chk({tag, "_vld"},  uart_din_vld, 0);
    chk({tag, "_din"},  uart_din,     0);
    chk({tag, "_gid"},  grant_id,     0);
    chk({tag, "_busy"}, busy,         0);
    chk({tag, "_terr"}, timeout_err,  0);
  endtask

  task automatic do_reset();
    step();
    #3 rst = 1'b0;
    #1 check_zero("rst");
    step();
    step();
    #3 rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  int exp_order[6];
  int cnt, k_hit, g0;

  initial begin
    rst = 1'b0; uart_rfd = 1'b1; req_vld = '0; req_data = '0;
    auto_drop = 1'b1; hold_all = 1'b0; rand_req = 1'b0;
    tx_auto = 1'b0; tx_rand = 1'b0; tx_len = 1; tx_left = 0; ack_cycles = 0;

    repeat (3) step();
    check_zero("init");
    #3 rst = 1'b1;
    step();

    // Single requester 2, byte 0xA5
    set_req(2, 8'hA5);
    step();
    chk("t1_ack", req_ack, 4'b0100);
    chk("t1_vld", uart_din_vld, 1);
    chk("t1_din", uart_din, 8'hA5);
    chk("t1_gid", grant_id, 2);
    step(); step();
    uart_rfd = 1'b0;
    step();
    chk("t1_idle", busy, 0);
    chk("t1_terr", timeout_err, 0);
    uart_rfd = 1'b1;
    step();

    // All four held, transmitter low 20 cycles per byte
    do_reset();
    grants.delete();
    auto_drop = 1'b0; hold_all = 1'b1; tx_auto = 1'b1; tx_len = 20;
    for (int i = 0; i < N; i++) set_req(i, W'($urandom));
    ack_cycles = 0;
    for (int c = 0; c < 600 && grants.size() < 6; c++) step();
    chk("t2_ngrants", grants.size() >= 6, 1);
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) if (i < grants.size()) chk("t2_order", grants[i], exp_order[i]);
    chk("t2_ack_cycles", ack_cycles, grants.size());
    hold_all = 1'b0; auto_drop = 1'b1; req_vld = '0;
    repeat (30) step();

    // Rotation after a grant to 2: pending 1 and 3 -> 3 then 1
    grants.delete();
    tx_len = 3;
    set_req(2, W'($urandom));
    for (int c = 0; c < 50 && grants.size() < 1; c++) step();
    set_req(1, W'($urandom));
    set_req(3, W'($urandom));
    for (int c = 0; c < 200 && grants.size() < 3; c++) step();
    chk("t3_ngrants", grants.size(), 3);
    if (grants.size() >= 3) begin
      chk("t3_first", grants[0], 2);
      chk("t3_second", grants[1], 3);
      chk("t3_third", grants[2], 1);
    end
    repeat (10) step();
    tx_auto = 1'b0; uart_rfd = 1'b1;

    // Transmitter not ready for 50 cycles
    uart_rfd = 1'b0;
    set_req(0, 8'h3C);
    cnt = 0;
    repeat (50) begin
      step();
      if (req_ack != '0 || uart_din_vld) cnt++;
    end
    chk("t4_no_activity", cnt, 0);
    uart_rfd = 1'b1;
    step();
    chk("t4_ack", req_ack, 4'b0001);
    chk("t4_din", uart_din, 8'h3C);
    step(); step();
    uart_rfd = 1'b0;
    step();
    uart_rfd = 1'b1;
    step();

    // Watchdog: rfd stays high
    set_req(1, 8'h11);
    step();
    chk("t5_ack", req_ack, 4'b0010);
    set_req(3, 8'h33);
    k_hit = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (timeout_err) begin
        k_hit = k;
        break;
      end
    end
    chk("t5_tmo_cycle", k_hit, 16);
    step();
    chk("t5_terr_once", timeout_err, 0);
    chk("t5_next_ack", req_ack, 4'b1000);
    chk("t5_next_din", uart_din, 8'h33);
    repeat (20) step();

    // Reset during BUSY: pointer returns to 0
    set_req(2, 8'h22);
    step();
    chk("t6_gid", grant_id, 2);
    step(); step();
    set_req(0, 8'h00 ^ 8'h5A);
    set_req(3, 8'hC3);
    #3 rst = 1'b0;
    #1 check_zero("t6_rst");
    step(); step();
    #3 rst = 1'b1;
    step();
    chk("t6_ack", req_ack, 4'b0001);
    chk("t6_din", uart_din, 8'h5A);
    repeat (20) step();
    req_vld = '0;

    // Randomized traffic
    do_reset();
    auto_drop = 1'b0; rand_req = 1'b1; tx_auto = 1'b1; tx_rand = 1'b1; tx_left = 0;
    uart_rfd = 1'b1;
    g0 = grants.size();
    ack_cycles = 0;
    repeat (3000) step();
    chk("t7_ack_count", ack_cycles, grants.size() - g0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter among N_REQ byte producers, e.g. a command responder, a status reporter and a debug dump. It sits between the requesters and the transmitter's din/din_vld/rfd interface. It selects one pending requester, hands its byte to the transmitter with a one-cycle din_vld pulse, and waits for the transmitter to accept before the next grant. A watchdog recovers the arbiter if the transmitter never acknowledges a byte.

Parameters:
N_REQ, 4, number of requester channels (1..16)
DI_WIDTH, 8, data width per requester and to the transmitter
TIMEOUT, 16, maximum cycles in BUSY waiting for uart_rfd to fall before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
req_vld  in  N_REQ  bit i: requester i holds a byte pending
req_data  in  N_REQ*DI_WIDTH  byte of requester i in bits [i*DI_WIDTH +: DI_WIDTH]
req_ack  out  N_REQ  one-cycle pulse on bit i when requester i's byte is taken
uart_din  out  DI_WIDTH  byte to the transmitter
uart_din_vld  out  1  one-cycle strobe to the transmitter
uart_rfd  in  1  transmitter ready for data (high = idle)
grant_id  out  max(1,clog2(N_REQ))  index of last granted requester
busy  out  1  high in SEND and BUSY
timeout_err  out  1  one-cycle pulse when the watchdog aborts

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; priority pointer ptr=0; watchdog counter 0. A byte in flight is abandoned and req_ack is not reissued.
- Requester contract:
  - Requester asserts req_vld[i] with stable req_data until it sees req_ack[i].
  - Deasserting before the ack is allowed; the byte is then simply not considered.
- Arbitration, combinational, in IDLE only:
  - Search req_vld starting at index ptr and wrapping modulo N_REQ.
  - The first set bit wins.
- IDLE: if uart_rfd=1 and any req_vld=1 in cycle T, then at the edge ending T:
  - state goes to SEND;
  - uart_din <= winner data; grant_id <= winner;
  - req_ack[winner] <= 1; uart_din_vld <= 1;
  - ptr <= (winner+1) mod N_REQ.
  - If uart_rfd=0 or no request, stay in IDLE with no output activity.
- SEND (exactly one cycle, T+1):
  - req_ack and uart_din_vld are high this cycle only.
  - Next state BUSY; watchdog cleared to 0.
  - uart_din and grant_id hold until the next grant.
- BUSY:
  - uart_rfd=0: go to IDLE next cycle (transmitter accepted the byte).
  - Else watchdog increments. When the watchdog reaches TIMEOUT-1 with uart_rfd still 1, go to IDLE and pulse timeout_err for one cycle. The byte is counted as dropped.
- IDLE after BUSY waits for uart_rfd=1 again, so back-to-back grants are serialized by the transmitter frame time.
- Latency: request in cycle T with the transmitter idle gives ack and strobe in T+1. Minimum spacing between grants is 3 cycles plus the time rfd is low.
- Fairness: a continuously requesting channel waits at most N_REQ-1 other grants.
- Simultaneous events:
  - req_vld changing in SEND or BUSY is ignored until IDLE.
  - uart_rfd falling during SEND is handled by BUSY on the next cycle, which exits immediately.
- busy = (state != IDLE). Outputs are registered except busy, which is decoded from the state register.

Test Plan:
- Single requester 2 pulses req_vld[2] with data 0xA5 while rfd=1 -> in the next cycle req_ack=4'b0100, uart_din_vld=1, uart_din=0xA5, grant_id=2; rfd driven low 2 cycles later -> state returns to IDLE, no timeout_err.
- All four requesters held valid, with the transmitter model dropping rfd for 20 cycles per byte -> grant order 0,1,2,3,0,1; each req_ack is exactly one cycle wide.
- After a grant to requester 2, requesters 1 and 3 are pending -> the next grant goes to 3, then 1.
- req_vld[0]=1 while rfd=0 for 50 cycles -> no ack and no strobe; rfd rises -> ack in the following cycle.
- Grant issued with rfd held high forever (TIMEOUT=16) -> timeout_err pulses exactly once, 16 cycles after the SEND cycle; the arbiter then grants the next pending requester.
- rst pulled low during BUSY -> all outputs 0 immediately; after release, pending requester 0 is granted first (ptr=0).
